uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
- Sequences one UART transmit frame per accepted byte: start bit, LSB-first data, optional parity, stop bit(s).
- Contains the baud-tick counter, the bit-index counter, the shift register and the frame FSM.
- Counters use equality compare against the terminal value to advance, the same style as the team's comparator blocks.
- Upstream source feeds bytes through a valid/ready handshake; the tx line drives the pin directly.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit (100 MHz / 9600 baud); must be >= 2
- DATA_BITS, 8, data bits per frame; 5..8
- PARITY_EN, 0, 1 = insert parity bit after data
- PARITY_ODD, 0, 0 = even parity, 1 = odd; ignored when PARITY_EN = 0
- STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake
- tx_valid  input  1  source has a byte
- tx_ready  output  1  block can accept a byte this cycle
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset values (async, immediate): state = IDLE, tx = 1, tx_ready = 1, busy = 0, done = 0, all counters = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Handshake occurs on a rising edge with tx_valid = 1 and tx_ready = 1.
- tx_ready = 1 only in IDLE. tx_valid outside IDLE is ignored; the source must hold it.
- All outputs are registered.

Transitions:
- IDLE -> START on handshake. At that edge: shift register <= tx_data, parity <= XOR(tx_data) ^ PARITY_ODD, tx <= 0, busy <= 1, baud_cnt <= 0.
- Each bit lasts exactly CLKS_PER_BIT cycles. baud_cnt counts 0..CLKS_PER_BIT-1; bit end = (baud_cnt == CLKS_PER_BIT-1), then baud_cnt <= 0.
- START end -> DATA, tx <= shreg[0].
- DATA end: if bit_cnt == DATA_BITS-1, go to PARITY (PARITY_EN) or STOP. Otherwise shift right, bit_cnt++, tx <= next LSB.
- PARITY: tx = parity bit; at end -> STOP.
- STOP: tx = 1, stop_cnt counts to STOP_BITS-1. At the end of the last stop bit -> IDLE, with busy <= 0, tx_ready <= 1, done <= 1 for one cycle.

Timing:
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, from the handshake edge to the done edge.
- Back-to-back: earliest next handshake is the edge after done. This gives one extra idle-high cycle between frames.

Boundaries:
- tx_data changes after the handshake: no effect on the current frame.
- reset asserted mid-frame: tx goes to 1 immediately, frame abandoned, no done pulse.
- reset released: IDLE on the first edge.
- Counters never wrap past their terminals; unreachable encodings return to IDLE.

Test Plan:
- CLKS_PER_BIT=4, send 0xA5, no parity, 1 stop -> tx = 0, 1,0,1,0,0,1,0,1, 1, each for 4 clks; done 40 clks after handshake; busy high for those 40 clks.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit = 1; frame 44 clks. With PARITY_ODD=1 -> parity bit = 0.
- STOP_BITS=2, send 0xFF -> tx high for 8 clks after the last data bit; done at clk 44.
- tx_valid held high with 0x11 then 0x22 -> two frames; tx_ready low throughout frame 1; second handshake on the edge after done; both bytes decoded correctly.
- Assert reset at clk 15 of a 0x00 frame -> tx = 1 within the same cycle, busy = 0, tx_ready = 1, no done pulse. A new 0x3C frame afterwards transmits correctly.
- tx_valid pulsed during busy with 0x99 -> ignored; line carries only the original byte.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmits one UART frame per accepted byte.
// Frame = start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clocks. The counters
// advance on an equality match with their terminal value. All outputs are
// registered. The tx output is idle high.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic              PAR_ON    = (PARITY_EN != 0) ? 1'b1 : 1'b0;
  localparam logic              PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // The parity bit is the XOR of all data bits, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d,
                                      input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t               state_r, state_s;
  logic [BAUD_W-1:0]    baud_cnt_r, baud_cnt_s;
  logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic                 stop_cnt_r, stop_cnt_s;
  logic [DATA_BITS-1:0] shreg_r, shreg_s;
  logic                 parity_r, parity_s;
  logic                 tx_r, tx_s;
  logic                 ready_r, ready_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 bit_end_s;

  assign bit_end_s = (baud_cnt_r == BAUD_LAST);

  assign tx       = tx_r;
  assign tx_ready = ready_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // This block computes the next state and the next value of every output register.
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    stop_cnt_s = stop_cnt_r;
    shreg_s    = shreg_r;
    parity_s   = parity_r;
    tx_s       = tx_r;
    ready_s    = ready_r;
    busy_s     = busy_r;
    done_s     = 1'b0;

    case (state_r)
      S_IDLE: begin
        tx_s       = 1'b1;
        ready_s    = 1'b1;
        busy_s     = 1'b0;
        baud_cnt_s = '0;
        bit_cnt_s  = '0;
        stop_cnt_s = 1'b0;
        if (tx_valid && ready_r) begin
          // Handshake: the byte is captured here. Later changes to tx_data are ignored.
          state_s  = S_START;
          shreg_s  = tx_data;
          parity_s = parity_bit(tx_data, PAR_ODD);
          tx_s     = 1'b0;
          ready_s  = 1'b0;
          busy_s   = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_START: begin
        if (bit_end_s) begin
          baud_cnt_s = '0;
          state_s    = S_DATA;
          tx_s       = shreg_r[0];
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end_s) begin
          baud_cnt_s = '0;
          if (bit_cnt_r == BIT_LAST) begin
            if (PAR_ON) begin
              state_s = S_PARITY;
              tx_s    = parity_r;
            end else begin
              state_s    = S_STOP;
              tx_s       = 1'b1;
              stop_cnt_s = 1'b0;
            end
          end else begin
            shreg_s   = {1'b0, shreg_r[DATA_BITS-1:1]};
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
            tx_s      = shreg_r[1];
          end
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_end_s) begin
          baud_cnt_s = '0;
          state_s    = S_STOP;
          tx_s       = 1'b1;
          stop_cnt_s = 1'b0;
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_W'(1);
        end
      end

      S_STOP: begin
        tx_s = 1'b1;
        if (bit_end_s) begin
          baud_cnt_s = '0;
          if (stop_cnt_r == STOP_LAST) begin
            state_s = S_IDLE;
            busy_s  = 1'b0;
            ready_s = 1'b1;
            done_s  = 1'b1;
          end else begin
            stop_cnt_s = stop_cnt_r + 1'b1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_W'(1);
        end
      end

      default: begin
        // An unreachable encoding returns to a clean idle state.
        state_s    = S_IDLE;
        baud_cnt_s = '0;
        bit_cnt_s  = '0;
        stop_cnt_s = 1'b0;
        tx_s       = 1'b1;
        ready_s    = 1'b1;
        busy_s     = 1'b0;
      end
    endcase
  end

  // This block holds the state, the counters, the datapath and the registered outputs. Reset returns everything to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= '0;
      stop_cnt_r <= 1'b0;
      shreg_r    <= '0;
      parity_r   <= 1'b0;
      tx_r       <= 1'b1;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      stop_cnt_r <= stop_cnt_s;
      shreg_r    <= shreg_s;
      parity_r   <= parity_s;
      tx_r       <= tx_s;
      ready_r    <= ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

endmodule
